// File: rtl/pipe_ctrl_pkg.sv
// Shared stall-vector indices, controller states and a stall-mask helper for pipe_ctrl.
// Stall bit i = 1 holds that stage register; higher stages imply all younger ones are held too.
package pipe_ctrl_pkg;

    localparam int STALL_W     = 6;
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_WB    = 4;

    typedef enum logic {
        PCTL_RUN   = 1'b0,
        PCTL_REDIR = 1'b1
    } pctl_state_t;

    // Mask holding every stage from the PC up to and including stage 'top'.
    function automatic logic [STALL_W-1:0] stall_upto(input int top);
        logic [STALL_W-1:0] v;
        v = '0;
        for (int i = 0; i < STALL_W; i++) begin
            if (i <= top) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Stall-cycle and accepted-redirect counters; one cycle from enable to count, no backpressure.
// Counters wrap freely; synchronous active-high reset clears both.
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_en,
    input  logic             flush_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_en) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_en) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall and flush strobes are combinational, redirect is registered (1 cycle).
// Redirect request to IF is held stable until redirect_ready; a branch behind a MEM stall waits for EX release.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               ex_branch_flag,
    input  logic [XLEN-1:0]    ex_branch_target,
    input  logic               redirect_ready,
    output logic [STALL_W-1:0] stall,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    pctl_state_t        state;
    pctl_state_t        state_nx;
    logic [STALL_W-1:0] req_stall;
    logic               br_accept;
    logic               redir_done;

    always_comb begin
        req_stall  = '0;
        stall      = '0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        br_accept  = 1'b0;
        redir_done = 1'b0;
        state_nx   = state;

        if (stallreq_mem)     req_stall = stall_upto(STALL_WB);
        else if (stallreq_id) req_stall = stall_upto(STALL_IDEX);
        else if (stallreq_if) req_stall = stall_upto(STALL_IFID);

        // A branch sitting in a held EX stage is re-presented once MEM lets go.
        br_accept = (state == PCTL_RUN) && ex_branch_flag && !req_stall[STALL_EXMEM];

        if (br_accept) begin
            // The load-use stall is moot: the instruction in ID is on the wrong path.
            stall      = stallreq_if ? stall_upto(STALL_IFID) : '0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_nx   = PCTL_REDIR;
        end else begin
            stall      = req_stall;
            flush_idex = stallreq_id && !stallreq_mem;
            flush_ifid = stallreq_if && !stallreq_id && !stallreq_mem;
        end

        if (state == PCTL_REDIR) begin
            flush_ifid = 1'b1;
            if (redirect_ready) begin
                redir_done = 1'b1;
                state_nx   = PCTL_RUN;
            end
        end

        if (rst) begin
            stall      = '0;
            flush_ifid = 1'b0;
            flush_idex = 1'b0;
            br_accept  = 1'b0;
            redir_done = 1'b0;
            state_nx   = PCTL_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= PCTL_RUN;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state <= state_nx;
            if (br_accept) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= ex_branch_target;
            end else if (redir_done) begin
                redirect_valid <= 1'b0;
            end
        end
    end

    pipe_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_en  (stall[STALL_PC]),
        .flush_en  (redir_done),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

`ifndef SYNTHESIS
    // ID/EX holds a bubble while redirecting, so EX cannot legitimately resolve a branch.
    a_no_branch_in_redir: assert property (
        @(posedge clk) disable iff (rst) (state == PCTL_REDIR) |-> !ex_branch_flag
    ) else $error("pipe_ctrl: ex_branch_flag raised during REDIR");
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, branch redirect handshake, MEM-held branch, reset mid-redirect.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_mem;
    logic        ex_branch_flag;
    logic [31:0] ex_branch_target;
    logic        redirect_ready;
    logic [5:0]  stall;
    logic        flush_ifid, flush_idex;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_if      (stallreq_if),
        .stallreq_id      (stallreq_id),
        .stallreq_mem     (stallreq_mem),
        .ex_branch_flag   (ex_branch_flag),
        .ex_branch_target (ex_branch_target),
        .redirect_ready   (redirect_ready),
        .stall            (stall),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    // Inputs change at the negedge; outputs are examined 1ns later, well clear of the posedge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s_if, input logic s_id, input logic s_mem,
                         input logic br, input logic [31:0] tgt, input logic rdy);
        stallreq_if      = s_if;
        stallreq_id      = s_id;
        stallreq_mem     = s_mem;
        ex_branch_flag   = br;
        ex_branch_target = tgt;
        redirect_ready   = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        total++; if (stall !== 6'b000000) begin bad++; $display("FAIL reset_stall: got %b want 000000", stall); end
        total++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b%b want 00", flush_ifid, flush_idex); end
        total++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect: got v=%b pc=%h want v=0 pc=0", redirect_valid, redirect_pc); end
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_mem_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            total++; if (stall !== 6'b011111) begin bad++; $display("FAIL mem_stall[%0d]: got %b want 011111", i, stall); end
            total++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin bad++; $display("FAIL mem_noflush[%0d]: got %b%b want 00", i, flush_ifid, flush_idex); end
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL mem_stall_cnt: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_id_stall();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (stall !== 6'b000111) begin bad++; $display("FAIL id_stall: got %b want 000111", stall); end
        total++; if (flush_idex !== 1'b1 || flush_ifid !== 1'b0) begin bad++; $display("FAIL id_flush: got ifid=%b idex=%b want 0/1", flush_ifid, flush_idex); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (stall !== 6'b000000 || flush_idex !== 1'b0) begin bad++; $display("FAIL id_release: got %b idex=%b want 000000/0", stall, flush_idex); end
        total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL id_stall_cnt: got %0d want 4", stall_cnt); end
    endtask

    task automatic test_priority();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        total++; if (stall !== 6'b011111 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin bad++; $display("FAIL prio_all: got %b %b%b want 011111 00", stall, flush_ifid, flush_idex); end
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (stall !== 6'b000111 || flush_ifid !== 1'b0 || flush_idex !== 1'b1) begin bad++; $display("FAIL prio_id_if: got %b %b%b want 000111 01", stall, flush_ifid, flush_idex); end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (stall !== 6'b000011 || flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin bad++; $display("FAIL prio_if: got %b %b%b want 000011 10", stall, flush_ifid, flush_idex); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (stall_cnt !== 32'd7) begin bad++; $display("FAIL prio_stall_cnt: got %0d want 7", stall_cnt); end
    endtask

    task automatic test_branch_redirect();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1040, 1'b1);
        total++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1 || stall !== 6'b000000) begin bad++; $display("FAIL br_c0: got %b %b%b want 000000 11", stall, flush_ifid, flush_idex); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL br_c0_valid: got %b want 0", redirect_valid); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1040) begin bad++; $display("FAIL br_c1: got v=%b pc=%h want v=1 pc=00001040", redirect_valid, redirect_pc); end
        total++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin bad++; $display("FAIL br_c1_flush: got %b%b want 10", flush_ifid, flush_idex); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (redirect_valid !== 1'b0 || flush_ifid !== 1'b0) begin bad++; $display("FAIL br_c2_run: got v=%b ifid=%b want 0/0", redirect_valid, flush_ifid); end
        total++; if (flush_cnt !== 32'd1) begin bad++; $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); end
    endtask

    task automatic test_redirect_wait();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 1'b0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_2000) begin bad++; $display("FAIL wait_hold[%0d]: got v=%b pc=%h want v=1 pc=00002000", i, redirect_valid, redirect_pc); end
            total++; if (flush_ifid !== 1'b1 || flush_cnt !== 32'd1) begin bad++; $display("FAIL wait_flush[%0d]: got ifid=%b cnt=%0d want 1/1", i, flush_ifid, flush_cnt); end
            next_cycle();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (stall !== 6'b000011 || flush_ifid !== 1'b1) begin bad++; $display("FAIL wait_if_stall: got %b ifid=%b want 000011/1", stall, flush_ifid); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (redirect_valid !== 1'b0 || flush_cnt !== 32'd2) begin bad++; $display("FAIL wait_done: got v=%b cnt=%0d want 0/2", redirect_valid, flush_cnt); end
        total++; if (stall_cnt !== 32'd8) begin bad++; $display("FAIL wait_stall_cnt: got %0d want 8", stall_cnt); end
    endtask

    task automatic test_branch_override();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2100, 1'b1);
        total++; if (stall !== 6'b000000 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin bad++; $display("FAIL ovr_id: got %b %b%b want 000000 11", stall, flush_ifid, flush_idex); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (redirect_pc !== 32'h0000_2100) begin bad++; $display("FAIL ovr_id_pc: got %h want 00002100", redirect_pc); end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2200, 1'b1);
        total++; if (stall !== 6'b000011 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin bad++; $display("FAIL ovr_if: got %b %b%b want 000011 11", stall, flush_ifid, flush_idex); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (flush_cnt !== 32'd4 || stall_cnt !== 32'd9) begin bad++; $display("FAIL ovr_cnt: got %0d/%0d want flush 4 stall 9", flush_cnt, stall_cnt); end
    endtask

    task automatic test_mem_held_branch();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b1);
            total++; if (stall !== 6'b011111 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin bad++; $display("FAIL held[%0d]: got %b %b%b want 011111 00", i, stall, flush_ifid, flush_idex); end
            total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL held_valid[%0d]: got %b want 0", i, redirect_valid); end
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b1);
        total++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin bad++; $display("FAIL held_accept: got %b%b want 11", flush_ifid, flush_idex); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_3000) begin bad++; $display("FAIL held_redir: got v=%b pc=%h want v=1 pc=00003000", redirect_valid, redirect_pc); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (redirect_valid !== 1'b0 || flush_cnt !== 32'd5 || stall_cnt !== 32'd11) begin bad++; $display("FAIL held_done: got v=%b flush=%0d stall=%0d want 0/5/11", redirect_valid, flush_cnt, stall_cnt); end
    endtask

    task automatic test_reset_in_redir();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL rr_pre: got v=%b want 1", redirect_valid); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        total++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin bad++; $display("FAIL rr_redirect: got v=%b pc=%h want v=0 pc=0", redirect_valid, redirect_pc); end
        total++; if (stall !== 6'b000000 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin bad++; $display("FAIL rr_run: got %b %b%b want 000000 00", stall, flush_ifid, flush_idex); end
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin bad++; $display("FAIL rr_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        next_cycle();
        total++; if (flush_cnt !== 32'd0 || redirect_valid !== 1'b0) begin bad++; $display("FAIL rr_dropped: got cnt=%0d v=%b want 0/0", flush_cnt, redirect_valid); end
    endtask

    initial begin
        test_reset();
        test_mem_stall();
        test_id_stall();
        test_priority();
        test_branch_redirect();
        test_redirect_wait();
        test_branch_override();
        test_mem_held_branch();
        test_reset_in_redir();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
